gray2bin_rx: RTL and testbench
==============================

# gray2bin_rx

Receive-side Gray-code decoder: the inverse end of the team's binary-to-Gray encoder. It samples a Gray-coded bus driven from another clock domain or from an external source such as a rotary encoder or async pointer, and synchronizes it with two flops. It converts each legal single-bit step to binary and emits a one-cycle `bin_valid` pulse with a step direction. Multi-bit jumps are flagged as errors and counted.

## Interface
Parameters:
- `W`, 4: Gray/binary bus width, legal range 2..16.
- `ERRW`, 8: width of the saturating error counter.

Ports:
- `clk`: input, 1. Single system clock. All logic is rising-edge.
- `rst`: input, 1. Asynchronous, active-high reset.
- `gray_in`: input, W. Gray-coded value, asynchronous to `clk`.
- `clr_err`: input, 1. Synchronous clear of `err_cnt`.
- `bin_out`: output, W. Last accepted value in binary.
- `bin_valid`: output, 1. One-cycle pulse on each legal step.
- `dir`: output, 1. Direction of the last legal step: 1 = up (+1 mod 2^W), 0 = down.
- `err`: output, 1. One-cycle pulse on an illegal multi-bit change.
- `err_cnt`: output, ERRW. Saturating count of `err` pulses.

## Operation
- Synchronizer: `gray_in` passes through `s1` then `s2`. Both reset to 0.
- State machine: states INIT and RUN.
  - Reset forces INIT and clears the fill counter `fc` (2 bits) to 0.
  - In INIT, `fc` increments each cycle.
  - On the cycle `fc`==2, the block loads `gq` <= `s2` and `bin_out` <= gray2bin(`s2`), then moves to RUN. No `bin_valid` or `err` is asserted in INIT.
- In RUN, each cycle compute `d` = popcount(`s2` ^ `gq`):
  - `d`==0: no action. Pulses are low.
  - `d`==1: `gq` <= `s2`, `bin_out` <= gray2bin(`s2`), `bin_valid` <= 1. `dir` <= 1 if new == old+1 mod 2^W, else 0. Wrap at max to 0 is up; 0 to max is down.
  - `d`>=2: `gq` <= `s2`, `bin_out` <= gray2bin(`s2`) (resync), `err` <= 1. `bin_valid` stays 0 and `dir` keeps its value. `err_cnt` increments and saturates at 2^ERRW-1.
- gray2bin: `b[W-1]` = `g[W-1]`; `b[i]` = `b[i+1]` ^ `g[i]`.
- `clr_err`: `err_cnt` <= 0. If `clr_err` and an error occur in the same cycle, clear wins and the result is 0, but the `err` pulse is still emitted.
- Reset mid-operation discards all history. Decoding restarts in INIT.

## Timing
- Reset values: `bin_out`=0, `bin_valid`=0, `dir`=0, `err`=0, `err_cnt`=0, `s1`=`s2`=`gq`=0, state INIT.
- Reset is asynchronous: outputs go to reset values immediately on `rst` rising, not on a clock edge.
- After `rst` deasserts, the first `bin_out` load occurs at the 3rd rising edge.
- Latency: a `gray_in` change captured into `s1` at edge k updates `bin_out`, `bin_valid`, `dir` and `err` at edge k+2.
- `bin_valid` and `err` are each high for exactly one cycle per event. They are never high together.
- Back-to-back legal steps on consecutive cycles each produce their own pulse. There is no throughput limit beyond one event per cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `gray_pkg` holds:
  - the state type (INIT, RUN);
  - function `gray2bin(g)`;
  - function `popcount(v)`;
  - constant `FILL_CYCLES` = 2.
- Sub-module `sync_2ff` (parameterized width, async active-high reset to 0) implements `s1`/`s2` and is reusable across the codebase.
- The top level holds the FSM, the fill counter, the step classifier and the error counter.

## Test plan
All scenarios use W=4 and ERRW=8.
- Reset and settle: hold `gray_in`=0110 through reset. 3 edges after release, `bin_out`=4. `bin_valid`, `err` and `err_cnt` remain 0 throughout.
- Up step: from 0110, drive 0111. Two edges after capture, `bin_out`=5, `bin_valid` pulses for 1 cycle, `dir`=1.
- Wrap both ways: drive 1000 (15) to 0000. Result: `bin_out`=0, `dir`=1. Then drive 0000 to 1000. Result: `bin_out`=15, `dir`=0, and one `bin_valid` pulse each.
- Illegal jump: drive 0000 to 0011 (0 to 2). Result: `err` pulses once, `err_cnt`=1, `bin_out`=2, `bin_valid` stays 0, `dir` unchanged.
- Counter limits:
  - 300 illegal jumps give `err_cnt`=255 (saturated).
  - `clr_err` asserted on the same cycle as an error gives `err_cnt`=0 with the `err` pulse still visible.
- Reset mid-run: assert `rst` asynchronously while `bin_out`=9. All outputs are immediately 0. After release, `bin_out` reloads with no `bin_valid` pulse.

Source files
------------

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types, constants and helpers for the Gray-code receive path
//
// Purpose:
//   Common definitions for gray2bin_rx. The helpers work on a 16-bit container,
//   which is the widest supported bus. Callers zero-extend narrower buses on
//   the way in and truncate the result on the way out. Zero high bits do not
//   change either the Gray decode or the popcount.
//
// Contents:
//   state_t      - receiver FSM states (ST_INIT, ST_RUN)
//   FILL_CYCLES  - fill-counter value at which the synchronizer is primed
//   gray2bin()   - Gray to binary decode
//   popcount()   - number of set bits in a vector

package gray_pkg;

  localparam int GRAY_MAX_W = 16;
  localparam int CNT_W      = 5;

  localparam logic [1:0] FILL_CYCLES = 2'd2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Each binary bit is the XOR of its Gray bit and all Gray bits above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [GRAY_MAX_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous multi-bit bus
//
// Purpose:
//   Brings an asynchronous bus into the i_clk domain through two flop stages.
//   This block is only safe for buses that change at most one bit at a time,
//   such as Gray codes. Any multi-bit skew that it passes through has to be
//   detected downstream.
//
// Ports:
//   i_clk - sampling clock
//   i_rst - asynchronous active-high reset; both stages clear to 0
//   i_d   - asynchronous input bus
//   o_q   - synchronized output (second stage)

module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/gray2bin_rx.sv
// rtl/gray2bin_rx.sv - receive-side Gray decoder with step direction and error counting
//
// Purpose:
//   Synchronizes an asynchronous Gray-coded bus and tracks the last accepted
//   code. Each single-bit change is a legal step. A legal step updates bin_out,
//   pulses bin_valid and records whether the step was +1 or -1 mod 2^W. A
//   change of two or more bits resyncs to the new value, pulses err and bumps
//   a saturating error counter. After reset the block waits for the
//   synchronizer to fill, then silently loads the current code.
//
// Parameters:
//   W    - bus width, 2..16
//   ERRW - error counter width
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   gray_in   - Gray-coded input, asynchronous to clk
//   clr_err   - synchronous clear of err_cnt; it takes priority over an increment
//   bin_out   - last accepted value, in binary
//   bin_valid - one-cycle pulse on each legal step
//   dir       - direction of the last legal step (1 = up, 0 = down)
//   err       - one-cycle pulse on a multi-bit change
//   err_cnt   - saturating count of err pulses

module gray2bin_rx #(
  parameter int W    = 4,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    gray_in,
  input  logic            clr_err,
  output logic [W-1:0]    bin_out,
  output logic            bin_valid,
  output logic            dir,
  output logic            err,
  output logic [ERRW-1:0] err_cnt
);

  import gray_pkg::*;

  // Registered state
  state_t          r_state;
  logic [1:0]      r_fc;
  logic [W-1:0]    r_gq;
  logic [W-1:0]    r_bin;
  logic            r_valid;
  logic            r_dir;
  logic            r_err;
  logic [ERRW-1:0] r_err_cnt;

  // Combinational next-state and datapath
  logic [W-1:0]     w_s2;
  logic [W-1:0]     w_bin_new;
  logic [CNT_W-1:0] w_dist;
  logic             w_step_up;

  state_t          w_state_nxt;
  logic [1:0]      w_fc_nxt;
  logic [W-1:0]    w_gq_nxt;
  logic [W-1:0]    w_bin_nxt;
  logic            w_valid_nxt;
  logic            w_dir_nxt;
  logic            w_err_nxt;
  logic [ERRW-1:0] w_err_cnt_nxt;

  sync_2ff #(
    .WIDTH (W)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (gray_in),
    .o_q   (w_s2)
  );

  // The package helpers use a 16-bit container. The casts zero-extend the bus
  // on the way in and drop the unused upper bits on the way out.
  assign w_bin_new = W'(gray2bin(16'(w_s2)));
  assign w_dist    = popcount(16'(w_s2 ^ r_gq));

  // The addition is carried out at W bits, so the top-to-zero wrap counts as up.
  assign w_step_up = (w_bin_new == r_bin + W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_fc_nxt    = r_fc;
    w_gq_nxt    = r_gq;
    w_bin_nxt   = r_bin;
    w_valid_nxt = 1'b0;
    w_dir_nxt   = r_dir;
    w_err_nxt   = 1'b0;

    case (r_state)
      ST_INIT: begin
        // Wait until s2 holds a real sample of gray_in, then adopt it as the
        // baseline without reporting a step.
        w_fc_nxt = r_fc + 2'd1;
        if (r_fc == FILL_CYCLES) begin
          w_gq_nxt    = w_s2;
          w_bin_nxt   = w_bin_new;
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (w_dist == CNT_W'(1)) begin
          w_gq_nxt    = w_s2;
          w_bin_nxt   = w_bin_new;
          w_valid_nxt = 1'b1;
          w_dir_nxt   = w_step_up;
        end else if (w_dist >= CNT_W'(2)) begin
          // Resync to whatever arrived. The direction of an illegal jump is
          // meaningless, so dir keeps the value from the last legal step.
          w_gq_nxt  = w_s2;
          w_bin_nxt = w_bin_new;
          w_err_nxt = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (clr_err) begin
      w_err_cnt_nxt = '0;
    end else if (w_err_nxt && (r_err_cnt != {ERRW{1'b1}})) begin
      w_err_cnt_nxt = r_err_cnt + ERRW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_fc      <= 2'd0;
      r_gq      <= '0;
      r_bin     <= '0;
      r_valid   <= 1'b0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_fc      <= w_fc_nxt;
      r_gq      <= w_gq_nxt;
      r_bin     <= w_bin_nxt;
      r_valid   <= w_valid_nxt;
      r_dir     <= w_dir_nxt;
      r_err     <= w_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign bin_out   = r_bin;
  assign bin_valid = r_valid;
  assign dir       = r_dir;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gray2bin_rx.sv
// tb/tb_gray2bin_rx.sv - self-checking bench for gray2bin_rx (W=4, ERRW=8)

module tb_gray2bin_rx;

  localparam int W    = 4;
  localparam int ERRW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    gray_in = '0;
  logic            clr_err = 1'b0;
  logic [W-1:0]    bin_out;
  logic            bin_valid;
  logic            dir;
  logic            err;
  logic [ERRW-1:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gray2bin_rx #(.W(W), .ERRW(ERRW)) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .clr_err   (clr_err),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .dir       (dir),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: the binary value whose Gray encoding (b ^ b>>1) equals g.
  function automatic int g2b_ref(input int g);
    for (int b = 0; b < 16; b++) begin
      if (((b ^ (b >> 1)) & 15) == g) return b;
    end
    return -1;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gray(input int g);
    @(negedge clk);
    gray_in = 4'(g);
  endtask

  // Drive one code, then let it propagate for four edges while counting pulses.
  task automatic apply_gray(input int g, output int nv, output int ne);
    set_gray(g);
    nv = 0;
    ne = 0;
    repeat (4) begin
      tick();
      if (bin_valid) nv++;
      if (err) ne++;
    end
  endtask

  task automatic test_reset();
    int nv = 0, ne = 0;
    rst = 1'b1;
    gray_in = 4'b0110;
    repeat (3) tick();
    n_checks++; if (bin_out !== 4'd0) begin n_errors++; $display("FAIL reset_bin_out: got %0d want 0", bin_out); end
    n_checks++; if ({bin_valid, dir, err} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got valid/dir/err=%b want 000", {bin_valid, dir, err}); end
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    @(negedge clk);
    rst = 1'b0;
    tick(); if (bin_valid) nv++; if (err) ne++;
    tick(); if (bin_valid) nv++; if (err) ne++;
    n_checks++; if (bin_out !== 4'd0) begin n_errors++; $display("FAIL settle_early: got %0d want 0 after 2 edges", bin_out); end
    tick(); if (bin_valid) nv++; if (err) ne++;
    n_checks++; if (bin_out !== 4'd4) begin n_errors++; $display("FAIL settle_load: got %0d want 4 after 3 edges", bin_out); end
    repeat (3) begin tick(); if (bin_valid) nv++; if (err) ne++; end
    n_checks++; if (nv !== 0 || ne !== 0) begin n_errors++; $display("FAIL settle_pulses: got valid=%0d err=%0d want 0/0", nv, ne); end
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL settle_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_up_step();
    set_gray(4'b0111);
    tick();
    tick();
    n_checks++; if (bin_out !== 4'd4 || bin_valid !== 1'b0) begin n_errors++; $display("FAIL up_latency: got bin=%0d valid=%b want 4/0 at edge k+1", bin_out, bin_valid); end
    tick();
    n_checks++; if (bin_out !== 4'd5) begin n_errors++; $display("FAIL up_bin: got %0d want 5", bin_out); end
    n_checks++; if (bin_valid !== 1'b1 || dir !== 1'b1 || err !== 1'b0) begin n_errors++; $display("FAIL up_pulse: got valid/dir/err=%b%b%b want 110", bin_valid, dir, err); end
    tick();
    n_checks++; if (bin_valid !== 1'b0) begin n_errors++; $display("FAIL up_pulse_width: got valid=%b want 0 one cycle later", bin_valid); end
  endtask

  task automatic test_wrap();
    int nv, ne;
    for (int b = 6; b <= 15; b++) begin
      apply_gray(b2g(b), nv, ne);
      n_checks++; if (int'(bin_out) !== b || nv !== 1 || ne !== 0 || dir !== 1'b1) begin n_errors++; $display("FAIL walk_up_%0d: got bin=%0d v=%0d e=%0d dir=%b want %0d/1/0/1", b, bin_out, nv, ne, dir, b); end
    end
    apply_gray(4'b0000, nv, ne);
    n_checks++; if (bin_out !== 4'd0 || nv !== 1 || ne !== 0 || dir !== 1'b1) begin n_errors++; $display("FAIL wrap_up: got bin=%0d v=%0d e=%0d dir=%b want 0/1/0/1", bin_out, nv, ne, dir); end
    apply_gray(4'b1000, nv, ne);
    n_checks++; if (bin_out !== 4'd15 || nv !== 1 || ne !== 0 || dir !== 1'b0) begin n_errors++; $display("FAIL wrap_down: got bin=%0d v=%0d e=%0d dir=%b want 15/1/0/0", bin_out, nv, ne, dir); end
  endtask

  task automatic test_illegal();
    int nv, ne;
    apply_gray(4'b0000, nv, ne);
    n_checks++; if (bin_out !== 4'd0 || dir !== 1'b1 || nv !== 1) begin n_errors++; $display("FAIL illegal_setup: got bin=%0d dir=%b v=%0d want 0/1/1", bin_out, dir, nv); end
    apply_gray(4'b0011, nv, ne);
    n_checks++; if (ne !== 1 || nv !== 0) begin n_errors++; $display("FAIL illegal_pulses: got err=%0d valid=%0d want 1/0", ne, nv); end
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL illegal_err_cnt: got %0d want 1", err_cnt); end
    n_checks++; if (bin_out !== 4'd2 || dir !== 1'b1) begin n_errors++; $display("FAIL illegal_resync: got bin=%0d dir=%b want 2/1", bin_out, dir); end
  endtask

  task automatic test_saturation();
    int ne = 0, nv = 0, nboth = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      gray_in = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      tick();
      if (err) ne++;
      if (bin_valid) nv++;
      if (err && bin_valid) nboth++;
    end
    repeat (3) begin
      tick();
      if (err) ne++;
      if (bin_valid) nv++;
    end
    n_checks++; if (ne !== 300) begin n_errors++; $display("FAIL sat_err_pulses: got %0d want 300", ne); end
    n_checks++; if (nv !== 0 || nboth !== 0) begin n_errors++; $display("FAIL sat_valid: got valid=%0d both=%0d want 0/0", nv, nboth); end
    n_checks++; if (err_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_err_cnt: got %0d want 255", err_cnt); end
    n_checks++; if (bin_out !== 4'd2) begin n_errors++; $display("FAIL sat_bin: got %0d want 2", bin_out); end
  endtask

  task automatic test_clr_collision();
    int nv, ne;
    set_gray(4'b0000);
    tick();
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_checks++; if (err !== 1'b1 || bin_valid !== 1'b0) begin n_errors++; $display("FAIL clr_coll_pulse: got err=%b valid=%b want 1/0", err, bin_valid); end
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL clr_coll_cnt: got %0d want 0", err_cnt); end
    apply_gray(4'b0011, nv, ne);
    n_checks++; if (ne !== 1 || err_cnt !== 8'd1) begin n_errors++; $display("FAIL clr_recount: got err=%0d cnt=%0d want 1/1", ne, err_cnt); end
    @(negedge clk);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL clr_plain: got %0d want 0", err_cnt); end
  endtask

  task automatic test_reset_mid_run();
    int nv = 0, ne = 0, tv, te;
    for (int b = 3; b <= 9; b++) apply_gray(b2g(b), tv, te);
    n_checks++; if (bin_out !== 4'd9 || dir !== 1'b1) begin n_errors++; $display("FAIL midrst_setup: got bin=%0d dir=%b want 9/1", bin_out, dir); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bin_out !== 4'd0 || {bin_valid, dir, err} !== 3'b000 || err_cnt !== 8'd0) begin n_errors++; $display("FAIL midrst_async: got bin=%0d v/d/e=%b%b%b cnt=%0d want all 0", bin_out, bin_valid, dir, err, err_cnt); end
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    tick(); if (bin_valid) nv++; if (err) ne++;
    tick(); if (bin_valid) nv++; if (err) ne++;
    n_checks++; if (bin_out !== 4'd0) begin n_errors++; $display("FAIL midrst_fill: got %0d want 0 after 2 edges", bin_out); end
    tick(); if (bin_valid) nv++; if (err) ne++;
    n_checks++; if (bin_out !== 4'd9) begin n_errors++; $display("FAIL midrst_reload: got %0d want 9", bin_out); end
    repeat (2) begin tick(); if (bin_valid) nv++; if (err) ne++; end
    n_checks++; if (nv !== 0 || ne !== 0 || dir !== 1'b0 || err_cnt !== 8'd0) begin n_errors++; $display("FAIL midrst_quiet: got v=%0d e=%0d dir=%b cnt=%0d want 0/0/0/0", nv, ne, dir, err_cnt); end
  endtask

  // Random back-to-back traffic, one new code per cycle, against a value-level
  // model. A code driven at negedge j appears on the outputs at negedge j+3.
  // A clr_err driven at negedge j affects the value seen at negedge j+1.
  task automatic test_random();
    int pend[$];
    int g0, m_gq, m_bin, m_dir, m_cnt, prev_clr, cur_b, ng;
    rst = 1'b1;
    g0 = int'($urandom_range(0, 15));
    gray_in = 4'(g0);
    clr_err = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) tick();
    m_gq = g0; m_bin = g2b_ref(g0); m_dir = 0; m_cnt = 0; prev_clr = 0;
    cur_b = m_bin;
    pend.push_back(g0); pend.push_back(g0); pend.push_back(g0);
    for (int j = 0; j < 400; j++) begin
      int g, d, e_valid, e_err;
      @(negedge clk);
      g = pend.pop_front();
      d = $countones(g ^ m_gq);
      e_valid = 0;
      e_err = 0;
      if (d == 1) begin
        e_valid = 1;
        m_dir = (g2b_ref(g) == (m_bin + 1) % 16) ? 1 : 0;
        m_bin = g2b_ref(g);
      end else if (d >= 2) begin
        e_err = 1;
        m_bin = g2b_ref(g);
      end
      m_gq = g;
      if (prev_clr != 0) m_cnt = 0;
      else if (e_err != 0 && m_cnt < 255) m_cnt++;
      n_checks++; if (int'(bin_out) !== m_bin) begin n_errors++; $display("FAIL rnd_bin[%0d]: got %0d want %0d", j, bin_out, m_bin); end
      n_checks++; if (int'(bin_valid) !== e_valid) begin n_errors++; $display("FAIL rnd_valid[%0d]: got %b want %0d", j, bin_valid, e_valid); end
      n_checks++; if (int'(err) !== e_err) begin n_errors++; $display("FAIL rnd_err[%0d]: got %b want %0d", j, err, e_err); end
      n_checks++; if (int'(dir) !== m_dir) begin n_errors++; $display("FAIL rnd_dir[%0d]: got %b want %0d", j, dir, m_dir); end
      n_checks++; if (int'(err_cnt) !== m_cnt) begin n_errors++; $display("FAIL rnd_err_cnt[%0d]: got %0d want %0d", j, err_cnt, m_cnt); end
      case ($urandom_range(0, 9))
        0, 1, 2: ng = b2g(cur_b);
        3, 4, 5: ng = b2g((cur_b + 1) % 16);
        6, 7, 8: ng = b2g((cur_b + 15) % 16);
        default: ng = int'($urandom_range(0, 15));
      endcase
      cur_b = g2b_ref(ng);
      gray_in = 4'(ng);
      pend.push_back(ng);
      clr_err = ($urandom_range(0, 19) == 0);
      prev_clr = int'(clr_err);
    end
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_step();
    test_wrap();
    test_illegal();
    test_saturation();
    test_clr_collision();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
